// File: rtl/height_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : height_pkg
//  Description : Shared definitions for the column height ROM and its
//                arbiters. A ROM word packs the wall height, the texture
//                scale and the inverse distance of one screen column.
//                Contents: ROM geometry, field slice positions, a port-id
//                enum for two-way arbiters and small field-extraction helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package height_pkg;

  localparam int HEIGHT_ADDR_W   = 10;
  localparam int HEIGHT_DATA_W   = 40;
  localparam int HEIGHT_ADDR_MAX = 1023;

  // Word layout: HGT [39:32], TEX_SCALE [31:16] (Q8.8), INV_DIST [15:0] (Q8.8)
  localparam int HGT_MSB       = 39;
  localparam int HGT_LSB       = 32;
  localparam int TEX_SCALE_MSB = 31;
  localparam int TEX_SCALE_LSB = 16;
  localparam int INV_DIST_MSB  = 15;
  localparam int INV_DIST_LSB  = 0;

  // Identity of a requester on a two-way shared ROM.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  function automatic logic [7:0] hgt_of(input logic [HEIGHT_DATA_W-1:0] w);
    return w[HGT_MSB:HGT_LSB];
  endfunction

  function automatic logic [15:0] tex_scale_of(input logic [HEIGHT_DATA_W-1:0] w);
    return w[TEX_SCALE_MSB:TEX_SCALE_LSB];
  endfunction

  function automatic logic [15:0] inv_dist_of(input logic [HEIGHT_DATA_W-1:0] w);
    return w[INV_DIST_MSB:INV_DIST_LSB];
  endfunction

endpackage : height_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-requester round-robin arbiter. Turns an eligibility
//                vector into a one-hot (or empty) grant. When both
//                requesters are eligible the one not granted most recently
//                wins. The history flop only moves on an actual grant.
//  Ports       : clk   - clock
//                rst   - asynchronous active-high reset
//                elig  - [1:0] per-requester eligibility
//                grant - [1:0] one-hot grant, all-zero when nobody eligible
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
  import height_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  output logic [1:0] grant
);

  port_e r_last_grant;

  always_comb begin
    grant = 2'b00;
    if (elig == 2'b11) begin
      grant = (r_last_grant == PORT1) ? 2'b01 : 2'b10;
    end else begin
      grant = elig;
    end
  end

  // Resetting to PORT1 hands the very first tie to port 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= PORT1;
    end else if (grant[0]) begin
      r_last_grant <= PORT0;
    end else if (grant[1]) begin
      r_last_grant <= PORT1;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/height_rom_arb.sv
`default_nettype none
// ============================================================================
//  Module      : height_rom_arb
//  Description : Shares the single registered height ROM between the
//                raycaster column pipeline (port 0) and the sprite/minimap
//                unit (port 1). Tracks the ROM's one-cycle read latency and
//                holds each response in a 1-deep register until consumed.
//                Each port has at most one transaction outstanding.
//  Ports       : clk, rst                     - clock, async active-high reset
//                reqN_valid/reqN_addr/reqN_ready - request channel of port N
//                rspN_valid/rspN_data/rspN_ready - response channel of port N
//                rom_addr                     - ROM address, from grant mux
//                rom_data                     - ROM word, valid cycle after addr
//  Revision    : 1.0  initial release
// ============================================================================
module height_rom_arb
  import height_pkg::*;
#(
  parameter int ADDR_W = HEIGHT_ADDR_W,
  parameter int DATA_W = HEIGHT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              rsp0_ready,

  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              rsp1_ready,

  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  logic [1:0] w_req_valid;
  logic [1:0] w_rsp_ready;
  logic [1:0] w_elig;
  logic [1:0] w_grant;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic              r_inflight;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;

    // A port may issue only when nothing is outstanding for it: no read in
    // flight, and the holding register is empty or being drained this cycle.
    // Draining and issuing in the same cycle is what keeps rsp_valid
    // bubble-free apart from the unavoidable inflight cycle.
    assign w_elig[gi] = w_req_valid[gi] & ~r_inflight &
                        (~r_rsp_valid | w_rsp_ready[gi]);

    // Clearing r_inflight on reset is what discards ROM data belonging to a
    // read issued before reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_inflight  <= 1'b0;
        r_rsp_valid <= 1'b0;
        r_rsp_data  <= '0;
      end else begin
        r_inflight <= w_grant[gi];
        if (r_inflight) begin
          r_rsp_data  <= rom_data;
          r_rsp_valid <= 1'b1;
        end else if (w_rsp_ready[gi]) begin
          r_rsp_valid <= 1'b0;
        end
      end
    end
  end : g_port

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .elig  (w_elig),
    .grant (w_grant)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];

  // Ungranted cycles still read the ROM (at address 0); that word is ignored
  // because no port is inflight on the following cycle.
  always_comb begin
    rom_addr = '0;
    if (w_grant[0]) begin
      rom_addr = req0_addr;
    end else if (w_grant[1]) begin
      rom_addr = req1_addr;
    end
  end

  assign rsp0_valid = g_port[0].r_rsp_valid;
  assign rsp0_data  = g_port[0].r_rsp_data;
  assign rsp1_valid = g_port[1].r_rsp_valid;
  assign rsp1_data  = g_port[1].r_rsp_data;

endmodule : height_rom_arb
`default_nettype wire
